physics_stepper: RTL
====================

PHYSICS_STEPPER -- requirements
Module: physics_stepper

Interface
REQ-001 SHALL have parameters: POSITION_SIZE, default 8, signed position width; VELOCITY_SIZE, default 8, signed velocity width; ACCELERATION_SIZE, default 8, signed acceleration width; DT, default 1, timestep multiplier; TIMEOUT_CYCLES, default 255, maximum wait for result_in.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have these ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- frame_in  input  1  single-cycle step request
- init_valid_in  input  1  load initial state
- init_pos_x_in, init_pos_y_in  input  POSITION_SIZE  initial position
- init_vel_x_in, init_vel_y_in  input  VELOCITY_SIZE  initial velocity
- acceleration_x_in, acceleration_y_in  input  ACCELERATION_SIZE  per-step acceleration
- begin_out  output  1  start pulse to collision engine
- pos_x_out, pos_y_out  output  POSITION_SIZE  current position, also the engine operand
- vel_x_out, vel_y_out  output  VELOCITY_SIZE  current velocity, also the engine operand
- acceleration_x_out, acceleration_y_out  output  ACCELERATION_SIZE  registered acceleration operand
- result_in  input  1  engine result valid pulse
- new_pos_x_in, new_pos_y_in  input  POSITION_SIZE  engine position result
- new_vel_x_in, new_vel_y_in  input  VELOCITY_SIZE  engine velocity result
- busy_out  output  1  high in ISSUE and WAIT
- step_done_out  output  1  one-cycle pulse per accepted result
- timeout_out  output  1  one-cycle pulse on abandoned step
- overrun_out  output  1  one-cycle pulse on dropped frame
- step_count_out  output  16  count of completed steps, wraps at 65535 to 0

Function
REQ-004 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE, with no other states.
REQ-005 In IDLE with init_valid_in high, SHALL load pos and vel from init_* on the next edge.
REQ-006 In IDLE with (frame_in or pending) high and init_valid_in low, SHALL enter ISSUE, latch acceleration_*_in into acceleration_*_out, and clear pending.
REQ-007 If init_valid_in and frame_in are both high in IDLE, SHALL perform the init load and set pending, so the frame issues one cycle later.
REQ-008 SHALL drive begin_out high for exactly the one ISSUE cycle and then enter WAIT unconditionally.
REQ-009 Frame sampled at edge N in IDLE SHALL produce begin_out high during cycle N+1.
REQ-010 pos/vel/acceleration outputs SHALL remain constant from ISSUE through WAIT.
REQ-011 In WAIT with result_in high at edge M, SHALL set pos = new_pos_*_in.
REQ-012 In WAIT with result_in high at edge M, SHALL set vel = sat(new_vel_*_in + acceleration_*_out * DT).
REQ-013 In WAIT with result_in high at edge M, SHALL pulse step_done_out in cycle M+1, increment step_count_out, and return to IDLE.
REQ-014 SHALL compute the velocity sum at full width (VELOCITY_SIZE+ACCELERATION_SIZE+8 bits) and clamp it to [-2^(VELOCITY_SIZE-1), 2^(VELOCITY_SIZE-1)-1].
REQ-015 SHALL count WAIT cycles.
REQ-016 When the WAIT count reaches TIMEOUT_CYCLES with result_in low, SHALL pulse timeout_out, leave pos/vel/step_count unchanged, and return to IDLE.
REQ-017 result_in in the same cycle the WAIT count reaches TIMEOUT_CYCLES SHALL win: normal update, no timeout pulse.
REQ-018 result_in outside WAIT SHALL be ignored.
REQ-019 frame_in while busy or in the ISSUE/WAIT exit cycle SHALL set the single-entry pending flag.
REQ-020 frame_in while pending is already set SHALL pulse overrun_out and be dropped.
REQ-021 init_valid_in outside IDLE SHALL be ignored.

Reset
REQ-022 With rst_in low at a clock edge, SHALL force IDLE and clear pending, the WAIT counter, and step_count_out.
REQ-023 With rst_in low at a clock edge, SHALL clear pos, vel, acceleration outputs, begin_out, step_done_out, timeout_out, overrun_out, and busy_out to 0.
REQ-024 Reset mid-WAIT SHALL abandon the step; a later result_in SHALL be ignored.

Verification
REQ-025 Init pos (-4,-7), vel (6,1); accel (0,-1); frame; model returns new_pos (2,-6), new_vel (6,1) after 5 cycles -> begin_out high exactly 1 cycle; pos (2,-6); vel (6,0); step_done_out 1 pulse; step_count_out 1.
REQ-026 Saturation: new_vel (127,-128) with accel (1,-1) -> vel (127,-128); new_vel (-100,100) with accel (-100,100) -> vel (-128,127).
REQ-027 TIMEOUT_CYCLES=16, model never responds -> timeout_out pulse 16 cycles after WAIT entry; pos/vel/step_count unchanged; busy_out low; late result_in ignored.
REQ-028 Two frames during WAIT -> overrun_out pulse on the second; after the result, a second begin_out follows in IDLE+1; step_count_out ends at 2.
REQ-029 rst_in low for 1 cycle mid-WAIT, then result_in -> all outputs 0, state IDLE, no step_done_out.
REQ-030 init_valid_in and frame_in in the same IDLE cycle -> init values appear on pos/vel_out before begin_out and are the engine operands.

Source files
------------

// File: rtl/physics_stepper_if.sv
// Engine-side handshake between the physics stepper and the collision engine.
// The stepper presents operands plus a begin pulse; the engine answers with a result pulse.
interface physics_stepper_if #(
   parameter int POSITION_SIZE     = 8,
   parameter int VELOCITY_SIZE     = 8,
   parameter int ACCELERATION_SIZE = 8
);
   logic                                begin_out;
   logic signed [POSITION_SIZE-1:0]     pos_x_out;
   logic signed [POSITION_SIZE-1:0]     pos_y_out;
   logic signed [VELOCITY_SIZE-1:0]     vel_x_out;
   logic signed [VELOCITY_SIZE-1:0]     vel_y_out;
   logic signed [ACCELERATION_SIZE-1:0] acceleration_x_out;
   logic signed [ACCELERATION_SIZE-1:0] acceleration_y_out;
   logic                                result_in;
   logic signed [POSITION_SIZE-1:0]     new_pos_x_in;
   logic signed [POSITION_SIZE-1:0]     new_pos_y_in;
   logic signed [VELOCITY_SIZE-1:0]     new_vel_x_in;
   logic signed [VELOCITY_SIZE-1:0]     new_vel_y_in;

   modport master (
      output begin_out, pos_x_out, pos_y_out, vel_x_out, vel_y_out,
             acceleration_x_out, acceleration_y_out,
      input  result_in, new_pos_x_in, new_pos_y_in, new_vel_x_in, new_vel_y_in
   );

   modport slave (
      input  begin_out, pos_x_out, pos_y_out, vel_x_out, vel_y_out,
             acceleration_x_out, acceleration_y_out,
      output result_in, new_pos_x_in, new_pos_y_in, new_vel_x_in, new_vel_y_in
   );
endinterface

// File: rtl/physics_stepper.sv
// Frame-driven 2D physics stepper: hands pos/vel/accel to a collision engine,
// then commits the engine's position and the saturated accelerated velocity.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | holding state; accepts init loads and frame requests
// S_ISSUE | one cycle, begin_out high, operands frozen
// S_WAIT  | waiting for result_in, bounded by the timeout down-counter
module physics_stepper #(
   parameter int POSITION_SIZE     = 8,
   parameter int VELOCITY_SIZE     = 8,
   parameter int ACCELERATION_SIZE = 8,
   parameter int DT                = 1,
   parameter int TIMEOUT_CYCLES    = 255
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                frame_in,
   input  logic                                init_valid_in,
   input  logic signed [POSITION_SIZE-1:0]     init_pos_x_in,
   input  logic signed [POSITION_SIZE-1:0]     init_pos_y_in,
   input  logic signed [VELOCITY_SIZE-1:0]     init_vel_x_in,
   input  logic signed [VELOCITY_SIZE-1:0]     init_vel_y_in,
   input  logic signed [ACCELERATION_SIZE-1:0] acceleration_x_in,
   input  logic signed [ACCELERATION_SIZE-1:0] acceleration_y_in,
   physics_stepper_if.master                   eng,
   output logic                                busy_out,
   output logic                                step_done_out,
   output logic                                timeout_out,
   output logic                                overrun_out,
   output logic [15:0]                         step_count_out
);
   localparam int SUM_W = VELOCITY_SIZE + ACCELERATION_SIZE + 8;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic signed [SUM_W-1:0] DT_S     = SUM_W'(DT);
   localparam logic signed [SUM_W-1:0] VMAX     = SUM_W'((1 <<< (VELOCITY_SIZE - 1)) - 1);
   localparam logic signed [SUM_W-1:0] VMIN     = -VMAX - SUM_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic                            r_pending;
   logic                            w_pending_nxt;
   logic [CNT_W-1:0]                r_wait_cnt;
   logic signed [POSITION_SIZE-1:0] r_pos_x, r_pos_y;
   logic signed [VELOCITY_SIZE-1:0] r_vel_x, r_vel_y;
   logic signed [ACCELERATION_SIZE-1:0] r_acc_x, r_acc_y;
   logic [15:0]                     r_step_count;
   logic                            r_step_done, r_timeout, r_overrun;
   logic                            w_load_init, w_latch_acc, w_accept, w_timeout, w_overrun;

   function automatic logic signed [VELOCITY_SIZE-1:0] sat_vel(
      input logic signed [VELOCITY_SIZE-1:0]     nv,
      input logic signed [ACCELERATION_SIZE-1:0] acc
   );
      logic signed [SUM_W-1:0] s;
      s = $signed({{(SUM_W-VELOCITY_SIZE){nv[VELOCITY_SIZE-1]}}, nv})
        + $signed({{(SUM_W-ACCELERATION_SIZE){acc[ACCELERATION_SIZE-1]}}, acc}) * DT_S;
      if (s > VMAX)      sat_vel = VMAX[VELOCITY_SIZE-1:0];
      else if (s < VMIN) sat_vel = VMIN[VELOCITY_SIZE-1:0];
      else               sat_vel = s[VELOCITY_SIZE-1:0];
   endfunction

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_load_init   = 1'b0;
      w_latch_acc   = 1'b0;
      w_accept      = 1'b0;
      w_timeout     = 1'b0;
      w_overrun     = 1'b0;
      // A frame is remembered once; a second one while still remembered is dropped.
      if (frame_in) begin
         if (r_pending) w_overrun     = 1'b1;
         else           w_pending_nxt = 1'b1;
      end
      case (r_state)
         S_IDLE: begin
            if (init_valid_in) begin
               w_load_init = 1'b1;
            end else if (frame_in || r_pending) begin
               w_state_nxt   = S_ISSUE;
               w_latch_acc   = 1'b1;
               w_pending_nxt = 1'b0;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (eng.result_in) begin
               w_accept    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_wait_cnt == '0) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state      <= S_IDLE;
         r_pending    <= 1'b0;
         r_wait_cnt   <= '0;
         r_pos_x      <= '0;
         r_pos_y      <= '0;
         r_vel_x      <= '0;
         r_vel_y      <= '0;
         r_acc_x      <= '0;
         r_acc_y      <= '0;
         r_step_count <= '0;
         r_step_done  <= 1'b0;
         r_timeout    <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pending   <= w_pending_nxt;
         r_step_done <= w_accept;
         r_timeout   <= w_timeout;
         r_overrun   <= w_overrun;
         if (r_state == S_ISSUE)
            r_wait_cnt <= CNT_LOAD;
         else if (r_state == S_WAIT && r_wait_cnt != '0)
            r_wait_cnt <= r_wait_cnt - 1'b1;
         if (w_load_init) begin
            r_pos_x <= init_pos_x_in;
            r_pos_y <= init_pos_y_in;
            r_vel_x <= init_vel_x_in;
            r_vel_y <= init_vel_y_in;
         end
         if (w_latch_acc) begin
            r_acc_x <= acceleration_x_in;
            r_acc_y <= acceleration_y_in;
         end
         if (w_accept) begin
            r_pos_x      <= eng.new_pos_x_in;
            r_pos_y      <= eng.new_pos_y_in;
            r_vel_x      <= sat_vel(eng.new_vel_x_in, r_acc_x);
            r_vel_y      <= sat_vel(eng.new_vel_y_in, r_acc_y);
            r_step_count <= r_step_count + 16'd1;
         end
      end
   end

   assign eng.begin_out          = (r_state == S_ISSUE);
   assign eng.pos_x_out          = r_pos_x;
   assign eng.pos_y_out          = r_pos_y;
   assign eng.vel_x_out          = r_vel_x;
   assign eng.vel_y_out          = r_vel_y;
   assign eng.acceleration_x_out = r_acc_x;
   assign eng.acceleration_y_out = r_acc_y;
   assign busy_out               = (r_state != S_IDLE);
   assign step_done_out          = r_step_done;
   assign timeout_out            = r_timeout;
   assign overrun_out            = r_overrun;
   assign step_count_out         = r_step_count;
endmodule
